// File: rtl/hog_scale_sequencer.sv
// AXI-Lite master that replays a table of HOG scale jobs: five register writes
// per job, then a wait for the write-done interrupt before the next job.
module hog_scale_sequencer #(
  parameter int AXIL_AW = 7,
  parameter int AXIL_DW = 32,
  parameter int JOB_AW  = 3,
  parameter int TIMEOUT = 2**20,
  parameter logic [AXIL_AW-1:0] OFS_SCALE_X = AXIL_AW'(7'h20),
  parameter logic [AXIL_AW-1:0] OFS_SCALE_Y = AXIL_AW'(7'h24),
  parameter logic [AXIL_AW-1:0] OFS_SCALE_N = AXIL_AW'(7'h28),
  parameter logic [AXIL_AW-1:0] OFS_WR_ADDR = AXIL_AW'(7'h1C),
  parameter logic [AXIL_AW-1:0] OFS_START   = AXIL_AW'(7'h08)
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               job_we,
  input  logic [JOB_AW-1:0]  job_waddr,
  input  logic [127:0]       job_wdata,
  input  logic [JOB_AW:0]    num_jobs,
  input  logic               run,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err,
  output logic [JOB_AW:0]    jobs_done,
  input  logic [1:0]         irq_done,
  output logic [AXIL_AW-1:0] m_axil_awaddr,
  output logic [2:0]         m_axil_awprot,
  output logic               m_axil_awvalid,
  input  logic               m_axil_awready,
  output logic [AXIL_DW-1:0] m_axil_wdata,
  output logic [3:0]         m_axil_wstrb,
  output logic               m_axil_wvalid,
  input  logic               m_axil_wready,
  input  logic [1:0]         m_axil_bresp,
  input  logic               m_axil_bvalid,
  output logic               m_axil_bready
);

  localparam int JOBS = 2**JOB_AW;
  localparam int TW   = $clog2(TIMEOUT);
  localparam logic [JOB_AW:0] JOBS_W = (JOB_AW+1)'(JOBS);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_RESP, S_WAIT, S_NEXT, S_FIN
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        reg_idx_r, reg_idx_s;
  logic              awvalid_r, awvalid_s;
  logic              wvalid_r, wvalid_s;
  logic              bready_r, bready_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [1:0]        err_r, err_s;
  logic [JOB_AW:0]   jobs_done_r, jobs_done_s;
  logic [JOB_AW:0]   num_r, num_s;
  logic [TW-1:0]     timer_r, timer_s;
  logic              irq_prev_r, irq_prev_s;
  logic [127:0]      job_q_r;
  logic [127:0]      table_mem [JOBS];
  logic              unused_irq_s;

  function automatic logic [AXIL_AW-1:0] reg_ofs(input logic [2:0] idx);
    case (idx)
      3'd0:    reg_ofs = OFS_SCALE_X;
      3'd1:    reg_ofs = OFS_SCALE_Y;
      3'd2:    reg_ofs = OFS_SCALE_N;
      3'd3:    reg_ofs = OFS_WR_ADDR;
      default: reg_ofs = OFS_START;
    endcase
  endfunction

  function automatic logic [AXIL_DW-1:0] reg_data(input logic [2:0] idx, input logic [127:0] q);
    case (idx)
      3'd0:    reg_data = AXIL_DW'(q[31:0]);
      3'd1:    reg_data = AXIL_DW'(q[63:32]);
      3'd2:    reg_data = AXIL_DW'(q[95:64]);
      3'd3:    reg_data = AXIL_DW'(q[127:96]);
      default: reg_data = AXIL_DW'(32'h1);
    endcase
  endfunction

  // Job table: written only while idle, no reset on the storage itself
  always_ff @(posedge aclk) begin
    if (job_we && (state_r == S_IDLE)) begin
      table_mem[job_waddr] <= job_wdata;
    end
  end

  // Table read port, captured once per job so address/data stay stable during ISSUE
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      job_q_r <= 128'd0;
    end else if (state_r == S_FETCH) begin
      job_q_r <= table_mem[jobs_done_r[JOB_AW-1:0]];
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_s     = state_r;
    reg_idx_s   = reg_idx_r;
    awvalid_s   = awvalid_r;
    wvalid_s    = wvalid_r;
    bready_s    = bready_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    err_s       = err_r;
    jobs_done_s = jobs_done_r;
    num_s       = num_r;
    timer_s     = timer_r;
    irq_prev_s  = irq_prev_r;
    case (state_r)
      S_IDLE: begin
        if (run) begin
          busy_s      = 1'b1;
          err_s       = 2'b00;
          jobs_done_s = '0;
          num_s       = (num_jobs > JOBS_W) ? JOBS_W : num_jobs;
          state_s     = (num_jobs == '0) ? S_FIN : S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        reg_idx_s = 3'd0;
        awvalid_s = 1'b1;
        wvalid_s  = 1'b1;
        state_s   = S_ISSUE;
      end
      S_ISSUE: begin
        awvalid_s = awvalid_r & ~m_axil_awready;
        wvalid_s  = wvalid_r & ~m_axil_wready;
        if ((~awvalid_r | m_axil_awready) & (~wvalid_r | m_axil_wready)) begin
          bready_s = 1'b1;
          state_s  = S_RESP;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_RESP: begin
        if (m_axil_bvalid && bready_r) begin
          bready_s = 1'b0;
          if (m_axil_bresp != 2'b00) begin
            err_s[0] = 1'b1;
            state_s  = S_FIN;
          end else if (reg_idx_r < 3'd4) begin
            reg_idx_s = reg_idx_r + 3'd1;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
            state_s   = S_ISSUE;
          end else begin
            // Prime the edge detector so a level already high is not taken as done
            timer_s    = '0;
            irq_prev_s = irq_done[1];
            state_s    = S_WAIT;
          end
        end else begin
          state_s = S_RESP;
        end
      end
      S_WAIT: begin
        irq_prev_s = irq_done[1];
        if (irq_done[1] && !irq_prev_r) begin
          jobs_done_s = jobs_done_r + (JOB_AW+1)'(1);
          state_s     = S_NEXT;
        end else if (timer_r == TW'(TIMEOUT-2)) begin
          // Fires one cycle early so done lands TIMEOUT cycles after WAIT entry
          err_s[1] = 1'b1;
          state_s  = S_FIN;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      S_NEXT: begin
        state_s = (jobs_done_r == num_r) ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        busy_s  = 1'b0;
        done_s  = 1'b1;
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and control registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r     <= S_IDLE;
      reg_idx_r   <= 3'd0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 2'b00;
      jobs_done_r <= '0;
      num_r       <= '0;
      timer_r     <= '0;
      irq_prev_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      reg_idx_r   <= reg_idx_s;
      awvalid_r   <= awvalid_s;
      wvalid_r    <= wvalid_s;
      bready_r    <= bready_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
      jobs_done_r <= jobs_done_s;
      num_r       <= num_s;
      timer_r     <= timer_s;
      irq_prev_r  <= irq_prev_s;
    end
  end

  // Address/data are gated by their valids so the bus reads zero when idle
  assign m_axil_awaddr  = awvalid_r ? reg_ofs(reg_idx_r) : '0;
  assign m_axil_wdata   = wvalid_r ? reg_data(reg_idx_r, job_q_r) : '0;
  assign m_axil_awvalid = awvalid_r;
  assign m_axil_wvalid  = wvalid_r;
  assign m_axil_bready  = bready_r;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_wstrb   = 4'hF;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign jobs_done      = jobs_done_r;
  assign unused_irq_s   = irq_done[0];

endmodule

// File: tb/tb_hog_scale_sequencer.sv
// Directed bench for hog_scale_sequencer: a cycle-stepped AXI-Lite slave and
// interrupt source, with per-scenario tasks checking against hand-built tables.
module tb_hog_scale_sequencer;

  localparam int TMO = 64;

  logic         aclk = 1'b0;
  logic         areset;
  logic         job_we;
  logic [2:0]   job_waddr;
  logic [127:0] job_wdata;
  logic [3:0]   num_jobs;
  logic         run;
  logic         busy, done;
  logic [1:0]   err;
  logic [3:0]   jobs_done;
  logic [1:0]   irq_done;
  logic [6:0]   m_axil_awaddr;
  logic [2:0]   m_axil_awprot;
  logic         m_axil_awvalid, m_axil_awready;
  logic [31:0]  m_axil_wdata;
  logic [3:0]   m_axil_wstrb;
  logic         m_axil_wvalid, m_axil_wready;
  logic [1:0]   m_axil_bresp;
  logic         m_axil_bvalid, m_axil_bready;

  hog_scale_sequencer #(.TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset(areset), .job_we(job_we), .job_waddr(job_waddr),
    .job_wdata(job_wdata), .num_jobs(num_jobs), .run(run), .busy(busy),
    .done(done), .err(err), .jobs_done(jobs_done), .irq_done(irq_done),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Slave behaviour knobs
  int aw_delay, w_delay, err_idx, irq_delay, stop_on_start_b, pulse_busy_k;

  // Observations from the last sequence
  logic [6:0]  log_addr [0:127];
  logic [31:0] log_data [0:127];
  int n_writes, n_b, stab_err, first_aw_k, done_k, wait_entry_k, start_b_cnt;
  bit done_seen;

  function automatic logic [6:0] exp_addr(input int r);
    case (r)
      0:       exp_addr = 7'h20;
      1:       exp_addr = 7'h24;
      2:       exp_addr = 7'h28;
      3:       exp_addr = 7'h1C;
      default: exp_addr = 7'h08;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input int j, input int r);
    case (r)
      0:       exp_data = 32'h1100_0000 + 32'(j);
      1:       exp_data = 32'h2200_0000 + 32'(j);
      2:       exp_data = 32'h0000_0004 + 32'(j);
      3:       exp_data = 32'h8000_0000 + (32'(j) << 12);
      default: exp_data = 32'h0000_0001;
    endcase
  endfunction

  task automatic quiesce();
    m_axil_awready = 1'b0;
    m_axil_wready  = 1'b0;
    m_axil_bvalid  = 1'b0;
    m_axil_bresp   = 2'b00;
    irq_done       = 2'b00;
  endtask

  task automatic default_cfg();
    aw_delay = 0; w_delay = 0; err_idx = -1; irq_delay = 20;
    stop_on_start_b = -1; pulse_busy_k = -10;
  endtask

  task automatic load_table();
    for (int j = 0; j < 8; j++) begin
      @(negedge aclk);
      job_we = 1'b1;
      job_waddr = 3'(j);
      job_wdata = {exp_data(j, 3), exp_data(j, 2), exp_data(j, 1), exp_data(j, 0)};
    end
    @(negedge aclk);
    job_we = 1'b0;
  endtask

  // Pulses run, then steps one negedge at a time acting as AXI-Lite slave and irq source
  task automatic run_sequence(input logic [3:0] n, input int budget);
    bit aw_hold, w_hold, have_a, have_d, b_pend, last_is_start;
    logic [6:0] aw_val, cap_a;
    logic [31:0] w_val, cap_d;
    int aw_cnt, w_cnt, irq_cnt, irq_hi, stop_k;
    aw_hold = 0; w_hold = 0; have_a = 0; have_d = 0; b_pend = 0; last_is_start = 0;
    aw_val = '0; w_val = '0; cap_a = '0; cap_d = '0;
    aw_cnt = 0; w_cnt = 0; irq_cnt = -1; irq_hi = 0; stop_k = -1;
    n_writes = 0; n_b = 0; stab_err = 0; first_aw_k = -1; done_k = -1;
    wait_entry_k = -1; start_b_cnt = 0; done_seen = 0;
    quiesce();
    @(negedge aclk);
    num_jobs = n;
    run = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge aclk);
      if (k == 1) run = 1'b0;
      if (k == pulse_busy_k) begin
        run = 1'b1; num_jobs = 4'd1; job_we = 1'b1; job_waddr = 3'd0;
        job_wdata = {4{32'hDEAD_BEEF}};
      end else if (k == pulse_busy_k + 1) begin
        run = 1'b0; job_we = 1'b0;
      end
      if (done) begin
        done_seen = 1; done_k = k;
      end
      if (m_axil_bvalid) begin
        m_axil_bvalid = 1'b0; n_b++; b_pend = 0;
      end else if (b_pend && m_axil_bready) begin
        m_axil_bvalid = 1'b1;
        m_axil_bresp = (n_writes - 1 == err_idx) ? 2'b10 : 2'b00;
        if (last_is_start && m_axil_bresp == 2'b00) begin
          wait_entry_k = k + 1;
          start_b_cnt++;
          if (irq_delay >= 0) irq_cnt = irq_delay;
          if (start_b_cnt == stop_on_start_b) stop_k = k + 6;
        end
      end
      if (irq_hi > 0) begin
        irq_hi--;
        if (irq_hi == 0) irq_done = 2'b00;
      end else if (irq_cnt > 0) begin
        irq_cnt--;
      end else if (irq_cnt == 0) begin
        irq_done = 2'b10; irq_hi = 3; irq_cnt = -1;
      end
      if (m_axil_awready) begin
        m_axil_awready = 1'b0; aw_hold = 0;
        if (m_axil_awvalid) stab_err++;
      end else if (m_axil_awvalid) begin
        if (first_aw_k < 0) first_aw_k = k;
        if (!aw_hold) begin
          aw_hold = 1; aw_val = m_axil_awaddr; aw_cnt = 0;
        end else begin
          aw_cnt++;
          if (m_axil_awaddr !== aw_val) stab_err++;
        end
        if (aw_cnt >= aw_delay) begin
          m_axil_awready = 1'b1; cap_a = aw_val; have_a = 1;
        end
      end
      if (m_axil_wready) begin
        m_axil_wready = 1'b0; w_hold = 0;
        if (m_axil_wvalid) stab_err++;
      end else if (m_axil_wvalid) begin
        if (!w_hold) begin
          w_hold = 1; w_val = m_axil_wdata; w_cnt = 0;
        end else begin
          w_cnt++;
          if (m_axil_wdata !== w_val) stab_err++;
        end
        if (w_cnt >= w_delay) begin
          m_axil_wready = 1'b1; cap_d = w_val; have_d = 1;
        end
      end
      if (have_a && have_d && n_writes < 128) begin
        log_addr[n_writes] = cap_a;
        log_data[n_writes] = cap_d;
        last_is_start = (cap_a == 7'h08);
        n_writes++;
        have_a = 0; have_d = 0; b_pend = 1;
      end
      if (done_seen || k == stop_k) break;
    end
    quiesce();
  endtask

  task automatic check_order(input string tag, input int njobs);
    for (int i = 0; i < njobs * 5; i++) begin
      checks++;
      if (log_addr[i] !== exp_addr(i % 5) || log_data[i] !== exp_data(i / 5, i % 5)) begin
        failures++;
        $display("FAIL %s write%0d got addr=%h data=%h exp addr=%h data=%h", tag, i,
                 log_addr[i], log_data[i], exp_addr(i % 5), exp_data(i / 5, i % 5));
      end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    checks++;
    if ({busy, done, err, jobs_done, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
         m_axil_awaddr, m_axil_wdata, m_axil_awprot} !== '0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b done=%b err=%b jd=%0d awv=%b wv=%b bready=%b exp all 0",
               busy, done, err, jobs_done, m_axil_awvalid, m_axil_wvalid, m_axil_bready);
    end
    checks++;
    if (m_axil_wstrb !== 4'hF) begin
      failures++; $display("FAIL reset_wstrb got=%h exp=f", m_axil_wstrb);
    end
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_two_jobs();
    default_cfg();
    run_sequence(4'd2, 600);
    checks++;
    if (!done_seen) begin failures++; $display("FAIL t1_done not seen within budget"); end
    checks++;
    if (first_aw_k != 2) begin failures++; $display("FAIL t1_aw_latency got=%0d exp=2", first_aw_k); end
    checks++;
    if (n_writes != 10 || n_b != 10) begin
      failures++; $display("FAIL t1_counts writes=%0d b=%0d exp 10/10", n_writes, n_b);
    end
    check_order("t1", 2);
    checks++;
    if (err !== 2'b00 || jobs_done !== 4'd2 || busy !== 1'b0) begin
      failures++; $display("FAIL t1_status err=%b jd=%0d busy=%b exp 00/2/0", err, jobs_done, busy);
    end
    @(negedge aclk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL t1_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_stall();
    for (int pass = 0; pass < 2; pass++) begin
      default_cfg();
      aw_delay = (pass == 0) ? 3 : 0;
      w_delay  = (pass == 0) ? 0 : 3;
      run_sequence(4'd2, 800);
      checks++;
      if (!done_seen || stab_err != 0) begin
        failures++; $display("FAIL t2_pass%0d done=%0d stability_errors=%0d exp 1/0", pass, done_seen, stab_err);
      end
      checks++;
      if (n_writes != 10 || n_b != n_writes) begin
        failures++; $display("FAIL t2_pass%0d_counts writes=%0d b=%0d exp 10/10", pass, n_writes, n_b);
      end
      check_order("t2", 2);
      checks++;
      if (err !== 2'b00 || jobs_done !== 4'd2) begin
        failures++; $display("FAIL t2_pass%0d_status err=%b jd=%0d exp 00/2", pass, err, jobs_done);
      end
    end
  endtask

  task automatic test_bresp_err();
    default_cfg();
    err_idx = 1;
    run_sequence(4'd2, 400);
    checks++;
    if (!done_seen || n_writes != 2 || n_b != 2) begin
      failures++; $display("FAIL t3_stop done=%0d writes=%0d b=%0d exp 1/2/2", done_seen, n_writes, n_b);
    end
    checks++;
    if (err !== 2'b01 || jobs_done !== 4'd0) begin
      failures++; $display("FAIL t3_status err=%b jd=%0d exp 01/0", err, jobs_done);
    end
  endtask

  task automatic test_timeout();
    default_cfg();
    irq_delay = -1;
    run_sequence(4'd1, 400);
    checks++;
    if (!done_seen || n_writes != 5) begin
      failures++; $display("FAIL t4_done done=%0d writes=%0d exp 1/5", done_seen, n_writes);
    end
    checks++;
    if (done_k - wait_entry_k != TMO) begin
      failures++; $display("FAIL t4_latency got=%0d exp=%0d", done_k - wait_entry_k, TMO);
    end
    checks++;
    if (err !== 2'b10 || jobs_done !== 4'd0) begin
      failures++; $display("FAIL t4_status err=%b jd=%0d exp 10/0", err, jobs_done);
    end
  endtask

  task automatic test_zero_and_ignored();
    default_cfg();
    run_sequence(4'd0, 50);
    checks++;
    if (done_k != 2 || first_aw_k != -1 || n_writes != 0) begin
      failures++; $display("FAIL t5_zero done_k=%0d first_aw=%0d writes=%0d exp 2/-1/0", done_k, first_aw_k, n_writes);
    end
    checks++;
    if (err !== 2'b00 || jobs_done !== 4'd0) begin
      failures++; $display("FAIL t5_zero_status err=%b jd=%0d exp 00/0", err, jobs_done);
    end
    default_cfg();
    pulse_busy_k = 5;
    run_sequence(4'd2, 600);
    checks++;
    if (!done_seen || n_writes != 10 || jobs_done !== 4'd2) begin
      failures++; $display("FAIL t5_busy_run done=%0d writes=%0d jd=%0d exp 1/10/2", done_seen, n_writes, jobs_done);
    end
    default_cfg();
    run_sequence(4'd1, 300);
    check_order("t5_table", 1);
  endtask

  task automatic test_clamp();
    default_cfg();
    irq_delay = 2;
    run_sequence(4'd9, 1500);
    checks++;
    if (!done_seen || n_writes != 40 || jobs_done !== 4'd8) begin
      failures++; $display("FAIL clamp done=%0d writes=%0d jd=%0d exp 1/40/8", done_seen, n_writes, jobs_done);
    end
    check_order("clamp", 8);
  endtask

  task automatic test_reset_abort();
    default_cfg();
    stop_on_start_b = 2;
    run_sequence(4'd2, 600);
    checks++;
    if (done_seen || n_writes != 10 || jobs_done !== 4'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL t6_pre done=%0d writes=%0d jd=%0d busy=%b exp 0/10/1/1", done_seen, n_writes, jobs_done, busy);
    end
    #1 areset = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, jobs_done, m_axil_awvalid, m_axil_wvalid, m_axil_bready} !== '0) begin
      failures++; $display("FAIL t6_abort busy=%b done=%b err=%b jd=%0d exp all 0", busy, done, err, jobs_done);
    end
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    default_cfg();
    run_sequence(4'd1, 300);
    checks++;
    if (!done_seen || n_writes != 5 || jobs_done !== 4'd1 || err !== 2'b00) begin
      failures++; $display("FAIL t6_restart done=%0d writes=%0d jd=%0d err=%b exp 1/5/1/00", done_seen, n_writes, jobs_done, err);
    end
    check_order("t6", 1);
  endtask

  initial begin
    areset = 1'b1; job_we = 1'b0; job_waddr = 3'd0; job_wdata = 128'd0;
    num_jobs = 4'd0; run = 1'b0;
    quiesce();
    test_reset();
    load_table();
    test_two_jobs();
    test_stall();
    test_bresp_err();
    test_timeout();
    test_zero_and_ignored();
    test_clamp();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
